// File: rtl/reorder_buffer_mc_if.sv
// Issue, writeback and commit bundle of the multi-commit reorder buffer.
// The master side is the core pipeline and the slave side is the ROB.
interface reorder_buffer_mc_if #(
  parameter int ROB_WIDTH    = 4,
  parameter int WB_PORTS     = 2,
  parameter int COMMIT_WIDTH = 2
) ();
  logic                             rdy_in;
  logic                             issue_valid;
  logic [1:0]                       issue_opcode;
  logic                             issue_value_ready;
  logic [31:0]                      issue_value;
  logic [31:0]                      issue_pc_pred;
  logic                             issue_ready;
  logic [ROB_WIDTH-1:0]             issue_tag;
  logic [ROB_WIDTH:0]               count;
  logic [WB_PORTS-1:0]              wb_valid;
  logic [WB_PORTS*ROB_WIDTH-1:0]    wb_tag;
  logic [WB_PORTS*32-1:0]           wb_value;
  logic [COMMIT_WIDTH-1:0]          cm_reg_valid;
  logic [COMMIT_WIDTH*ROB_WIDTH-1:0] cm_reg_tag;
  logic [COMMIT_WIDTH*32-1:0]       cm_reg_value;
  logic [COMMIT_WIDTH-1:0]          cm_store_valid;
  logic [COMMIT_WIDTH*ROB_WIDTH-1:0] cm_store_tag;
  logic                             clear_signal;
  logic [31:0]                      correct_pc;

  modport master (
    output rdy_in, issue_valid, issue_opcode, issue_value_ready, issue_value, issue_pc_pred,
    output wb_valid, wb_tag, wb_value,
    input  issue_ready, issue_tag, count,
    input  cm_reg_valid, cm_reg_tag, cm_reg_value, cm_store_valid, cm_store_tag,
    input  clear_signal, correct_pc
  );

  modport slave (
    input  rdy_in, issue_valid, issue_opcode, issue_value_ready, issue_value, issue_pc_pred,
    input  wb_valid, wb_tag, wb_value,
    output issue_ready, issue_tag, count,
    output cm_reg_valid, cm_reg_tag, cm_reg_value, cm_store_valid, cm_store_tag,
    output clear_signal, correct_pc
  );
endinterface

// File: rtl/reorder_buffer_mc.sv
// Circular reorder buffer with multi-port writeback, up to COMMIT_WIDTH
// in-order commits per cycle, and branch/jalr misprediction flush.
module reorder_buffer_mc #(
  parameter int ROB_WIDTH    = 4,
  parameter int WB_PORTS     = 2,
  parameter int COMMIT_WIDTH = 2
) (
  input logic               clk_in,
  input logic               rst_in,
  reorder_buffer_mc_if.slave bus
);
  localparam int ROB_SIZE = 1 << ROB_WIDTH;
  localparam logic [1:0] OP_REG = 2'b00, OP_STORE = 2'b01, OP_BRANCH = 2'b10, OP_JALR = 2'b11;

  logic [ROB_SIZE-1:0]  r_busy, r_ready;
  logic [1:0]           r_op    [ROB_SIZE];
  logic [31:0]          r_value [ROB_SIZE];
  logic [31:0]          r_pred  [ROB_SIZE];
  logic [31:0]          r_link  [ROB_SIZE];
  logic [ROB_WIDTH-1:0] r_head, r_tail;
  logic [ROB_WIDTH:0]   r_count;

  logic [COMMIT_WIDTH-1:0]           r_reg_v, r_st_v;
  logic [COMMIT_WIDTH*ROB_WIDTH-1:0] r_reg_tag, r_st_tag;
  logic [COMMIT_WIDTH*32-1:0]        r_reg_val;
  logic                              r_clear;
  logic [31:0]                       r_cpc;

  logic [COMMIT_WIDTH-1:0] w_cm;
  logic [ROB_WIDTH-1:0]    w_cm_idx [COMMIT_WIDTH];
  logic [ROB_WIDTH:0]      w_ncm;
  logic                    w_flush, w_go, w_issue_ready, w_issue;
  logic [31:0]             w_cpc;

  // Commit chain: each slot needs every older slot to commit without redirecting.
  always_comb begin
    w_cm    = '0;
    w_ncm   = '0;
    w_flush = 1'b0;
    w_cpc   = '0;
    w_go    = bus.rdy_in;
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      w_cm_idx[k] = r_head + ROB_WIDTH'(k);
      if (w_go && r_busy[w_cm_idx[k]] && r_ready[w_cm_idx[k]]) begin
        w_cm[k] = 1'b1;
        w_ncm   = w_ncm + (ROB_WIDTH+1)'(1);
        if (r_op[w_cm_idx[k]] == OP_BRANCH &&
            (r_value[w_cm_idx[k]][1] ^ r_value[w_cm_idx[k]][0])) begin
          w_flush = 1'b1;
          w_cpc   = r_value[w_cm_idx[k]] & 32'hFFFF_FFFC;
        end else if (r_op[w_cm_idx[k]] == OP_JALR &&
                     r_value[w_cm_idx[k]] != r_pred[w_cm_idx[k]]) begin
          w_flush = 1'b1;
          w_cpc   = r_value[w_cm_idx[k]];
        end
      end else begin
        w_go = 1'b0;
      end
      if (w_flush) w_go = 1'b0;
    end
  end

  assign w_issue_ready = (r_count < (ROB_WIDTH+1)'(ROB_SIZE)) && !w_flush;
  assign w_issue       = bus.rdy_in && bus.issue_valid && w_issue_ready;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_busy    <= '0;
      r_ready   <= '0;
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_reg_v   <= '0;
      r_st_v    <= '0;
      r_reg_tag <= '0;
      r_st_tag  <= '0;
      r_reg_val <= '0;
      r_clear   <= 1'b0;
      r_cpc     <= '0;
    end else if (bus.rdy_in) begin
      r_clear <= w_flush;
      for (int k = 0; k < COMMIT_WIDTH; k++) begin
        r_reg_v[k] <= w_cm[k] && (r_op[w_cm_idx[k]] == OP_REG || r_op[w_cm_idx[k]] == OP_JALR);
        r_st_v[k]  <= w_cm[k] && (r_op[w_cm_idx[k]] == OP_STORE);
        if (w_cm[k]) begin
          r_reg_tag[k*ROB_WIDTH +: ROB_WIDTH] <= w_cm_idx[k];
          r_st_tag[k*ROB_WIDTH +: ROB_WIDTH]  <= w_cm_idx[k];
          r_reg_val[k*32 +: 32] <= (r_op[w_cm_idx[k]] == OP_JALR) ? r_link[w_cm_idx[k]]
                                                                  : r_value[w_cm_idx[k]];
        end
      end
      if (w_flush) begin
        r_busy  <= '0;
        r_ready <= '0;
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
        r_cpc   <= w_cpc;
      end else begin
        for (int p = 0; p < WB_PORTS; p++) begin
          if (bus.wb_valid[p] && r_busy[bus.wb_tag[p*ROB_WIDTH +: ROB_WIDTH]])
            r_ready[bus.wb_tag[p*ROB_WIDTH +: ROB_WIDTH]] <= 1'b1;
        end
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
          if (w_cm[k]) begin
            r_busy[w_cm_idx[k]]  <= 1'b0;
            r_ready[w_cm_idx[k]] <= 1'b0;
          end
        end
        if (w_issue) begin
          r_busy[r_tail]  <= 1'b1;
          r_ready[r_tail] <= bus.issue_value_ready;
          r_tail          <= r_tail + ROB_WIDTH'(1);
        end
        r_head  <= r_head + w_ncm[ROB_WIDTH-1:0];
        r_count <= r_count + (ROB_WIDTH+1)'(w_issue) - w_ncm;
      end
    end else begin
      r_reg_v <= '0;
      r_st_v  <= '0;
      r_clear <= 1'b0;
    end
  end

  // Payload needs no reset: it is only observed through busy entries.
  // A jalr keeps its predicted target in value until the real one is written back.
  always_ff @(posedge clk_in) begin
    if (bus.rdy_in && !w_flush) begin
      for (int p = 0; p < WB_PORTS; p++) begin
        if (bus.wb_valid[p] && r_busy[bus.wb_tag[p*ROB_WIDTH +: ROB_WIDTH]]) begin
          if (r_op[bus.wb_tag[p*ROB_WIDTH +: ROB_WIDTH]] == OP_BRANCH)
            r_value[bus.wb_tag[p*ROB_WIDTH +: ROB_WIDTH]][0] <= bus.wb_value[p*32];
          else
            r_value[bus.wb_tag[p*ROB_WIDTH +: ROB_WIDTH]] <= bus.wb_value[p*32 +: 32];
        end
      end
      if (w_issue) begin
        r_op[r_tail]    <= bus.issue_opcode;
        r_value[r_tail] <= (bus.issue_opcode == OP_JALR) ? bus.issue_pc_pred : bus.issue_value;
        r_pred[r_tail]  <= bus.issue_pc_pred;
        r_link[r_tail]  <= bus.issue_value;
      end
    end
  end

  assign bus.issue_ready    = w_issue_ready;
  assign bus.issue_tag      = r_tail;
  assign bus.count          = r_count;
  assign bus.cm_reg_valid   = r_reg_v;
  assign bus.cm_reg_tag     = r_reg_tag;
  assign bus.cm_reg_value   = r_reg_val;
  assign bus.cm_store_valid = r_st_v;
  assign bus.cm_store_tag   = r_st_tag;
  assign bus.clear_signal   = r_clear;
  assign bus.correct_pc     = r_cpc;
endmodule

// File: tb/tb_reorder_buffer_mc.sv
// Bench for reorder_buffer_mc: directed scenarios then random traffic,
// all checked against a queue-based model of the buffer.
module tb_reorder_buffer_mc;
  localparam int RW = 4, WBP = 2, CW = 2, SIZE = 16;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  always #5 clk_in = ~clk_in;

  reorder_buffer_mc_if #(.ROB_WIDTH(RW), .WB_PORTS(WBP), .COMMIT_WIDTH(CW)) bus ();
  reorder_buffer_mc #(.ROB_WIDTH(RW), .WB_PORTS(WBP), .COMMIT_WIDTH(CW)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .bus(bus)
  );

  typedef struct {
    int        tag;
    bit        rdy;
    bit [1:0]  op;
    bit [31:0] val;
    bit [31:0] pred;
    bit [31:0] link;
  } ent_t;

  ent_t q[$];
  int   m_tail = 0;
  int   n_vec  = 0;
  int   n_err  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.rdy_in            = 1'b1;
    bus.issue_valid       = 1'b0;
    bus.issue_opcode      = 2'b00;
    bus.issue_value_ready = 1'b0;
    bus.issue_value       = '0;
    bus.issue_pc_pred     = '0;
    bus.wb_valid          = '0;
    bus.wb_tag            = '0;
    bus.wb_value          = '0;
  endtask

  task automatic set_wb(input int p, input int tag, input logic [31:0] v);
    bus.wb_valid[p]          = 1'b1;
    bus.wb_tag[p*RW +: RW]   = RW'(tag);
    bus.wb_value[p*32 +: 32] = v;
  endtask

  // One clock: check combinational outputs, predict the edge, check registered outputs.
  task automatic step();
    bit        flush = 0;
    int        ncm = 0;
    bit [CW-1:0] e_rv = '0, e_sv = '0;
    int        e_tag [CW];
    bit [31:0] e_val [CW];
    bit [31:0] e_cpc = '0;
    bit        acc;
    ent_t      ne;
    #1;
    if (bus.rdy_in) begin
      for (int k = 0; k < CW && k < q.size(); k++) begin
        if (!q[k].rdy) break;
        ncm++;
        e_tag[k] = q[k].tag;
        case (q[k].op)
          2'd0: begin e_rv[k] = 1; e_val[k] = q[k].val;  end
          2'd1: e_sv[k] = 1;
          2'd3: begin e_rv[k] = 1; e_val[k] = q[k].link; end
          default: ;
        endcase
        if (q[k].op == 2'd2 && q[k].val[1] != q[k].val[0]) begin
          flush = 1; e_cpc = {q[k].val[31:2], 2'b00};
        end
        if (q[k].op == 2'd3 && q[k].val != q[k].pred) begin
          flush = 1; e_cpc = q[k].val;
        end
        if (flush) break;
      end
    end
    check("issue_ready", 64'(bus.issue_ready), 64'(q.size() < SIZE && !flush));
    check("issue_tag", 64'(bus.issue_tag), 64'(m_tail));
    check("count", 64'(bus.count), 64'(q.size()));
    acc      = bus.rdy_in && bus.issue_valid && q.size() < SIZE && !flush;
    ne.tag   = m_tail;
    ne.rdy   = bus.issue_value_ready;
    ne.op    = bus.issue_opcode;
    ne.val   = (bus.issue_opcode == 2'd3) ? bus.issue_pc_pred : bus.issue_value;
    ne.pred  = bus.issue_pc_pred;
    ne.link  = bus.issue_value;
    @(posedge clk_in);
    #1;
    for (int k = 0; k < CW; k++) begin
      check($sformatf("reg_v%0d", k), 64'(bus.cm_reg_valid[k]), 64'(e_rv[k]));
      check($sformatf("st_v%0d", k), 64'(bus.cm_store_valid[k]), 64'(e_sv[k]));
      if (e_rv[k]) begin
        check($sformatf("reg_tag%0d", k), 64'(bus.cm_reg_tag[k*RW +: RW]), 64'(e_tag[k]));
        check($sformatf("reg_val%0d", k), 64'(bus.cm_reg_value[k*32 +: 32]), 64'(e_val[k]));
      end
      if (e_sv[k]) check($sformatf("st_tag%0d", k), 64'(bus.cm_store_tag[k*RW +: RW]), 64'(e_tag[k]));
    end
    check("clear", 64'(bus.clear_signal), 64'(flush));
    if (flush) check("correct_pc", 64'(bus.correct_pc), 64'(e_cpc));
    if (bus.rdy_in) begin
      if (flush) begin
        q.delete();
        m_tail = 0;
      end else begin
        for (int p = 0; p < WBP; p++) begin
          if (bus.wb_valid[p]) begin
            foreach (q[i]) begin
              if (q[i].tag == int'(bus.wb_tag[p*RW +: RW])) begin
                if (q[i].op == 2'd2) q[i].val[0] = bus.wb_value[p*32];
                else q[i].val = bus.wb_value[p*32 +: 32];
                q[i].rdy = 1;
              end
            end
          end
        end
        repeat (ncm) void'(q.pop_front());
        if (acc) begin
          q.push_back(ne);
          m_tail = (m_tail + 1) % SIZE;
        end
      end
    end
  endtask

  task automatic issue(input logic [1:0] op, input bit vr, input logic [31:0] v, input logic [31:0] pcp);
    idle();
    bus.issue_valid       = 1'b1;
    bus.issue_opcode      = op;
    bus.issue_value_ready = vr;
    bus.issue_value       = v;
    bus.issue_pc_pred     = pcp;
    step();
  endtask

  task automatic drain();
    for (int n = 0; n < 100 && q.size() > 0; n++) begin
      int p = 0;
      idle();
      foreach (q[i]) begin
        if (!q[i].rdy && p < WBP) begin
          set_wb(p, q[i].tag, (q[i].op == 2'd3) ? q[i].pred : $urandom);
          p++;
        end
      end
      step();
    end
    idle();
    step();
    check("drain_count", 64'(bus.count), 64'd0);
  endtask

  task automatic do_reset();
    #2 rst_in = 1'b0;
    #1;
    check("rst_reg_v", 64'(bus.cm_reg_valid), 64'd0);
    check("rst_st_v", 64'(bus.cm_store_valid), 64'd0);
    check("rst_clear", 64'(bus.clear_signal), 64'd0);
    check("rst_cpc", 64'(bus.correct_pc), 64'd0);
    check("rst_count", 64'(bus.count), 64'd0);
    check("rst_tag", 64'(bus.issue_tag), 64'd0);
    check("rst_reg_val", 64'(bus.cm_reg_value), 64'd0);
    q.delete();
    m_tail = 0;
    @(negedge clk_in);
    rst_in = 1'b1;
  endtask

  initial begin
    int hd;
    idle();
    do_reset();

    // Two entries written back together retire together.
    issue(2'd0, 0, 32'h11, 0);
    issue(2'd0, 0, 32'h22, 0);
    idle(); set_wb(0, 0, 32'h11); set_wb(1, 1, 32'h22); step();
    idle(); step();
    check("dual_v", 64'(bus.cm_reg_valid), 64'b11);
    check("dual_val", 64'(bus.cm_reg_value), 64'h00000022_00000011);
    issue(2'd0, 1, 32'h33, 0);
    issue(2'd1, 1, 32'h44, 0);
    idle(); step();

    // Full buffer.
    for (int i = 0; i < SIZE; i++) issue(2'd0, 0, 32'(i), 0);
    check("full_count", 64'(bus.count), 64'd16);
    issue(2'd0, 1, 32'hDEAD, 0);
    hd = q[0].tag;
    idle(); set_wb(0, hd, 32'h5A); step();
    idle(); step();
    check("full_cm_tag", 64'(bus.cm_reg_tag[RW-1:0]), 64'(hd));
    issue(2'd0, 0, 32'h77, 0);
    drain();

    // Branch mispredict blocks the younger ready entry.
    hd = m_tail;
    issue(2'd2, 0, 32'h0000_1002, 0);
    issue(2'd0, 1, 32'h55, 0);
    idle(); set_wb(0, hd, 32'h0); step();
    idle(); step();
    check("br_clear", 64'(bus.clear_signal), 64'd1);
    check("br_pc", 64'(bus.correct_pc), 64'h1000);
    check("br_young", 64'(bus.cm_reg_valid), 64'd0);
    idle(); step();

    // Jalr mispredict still commits its link.
    issue(2'd3, 0, 32'h104, 32'h200);
    idle(); set_wb(0, 0, 32'h300); step();
    idle(); step();
    check("jalr_v", 64'(bus.cm_reg_valid[0]), 64'd1);
    check("jalr_link", 64'(bus.cm_reg_value[31:0]), 64'h104);
    check("jalr_pc", 64'(bus.correct_pc), 64'h300);
    idle(); step();

    // Port priority on a shared tag, and a writeback to an empty slot.
    for (int i = 0; i < 4; i++) issue(2'd0, 0, 32'h0, 0);
    idle(); set_wb(0, 3, 32'hA); set_wb(1, 3, 32'hB); step();
    idle(); set_wb(0, 5, 32'h77); step();
    idle(); set_wb(0, 0, 32'h1); set_wb(1, 1, 32'h2); step();
    idle(); set_wb(0, 2, 32'h3); step();
    idle(); step();
    check("prio_tag", 64'(bus.cm_reg_tag[2*RW-1:RW]), 64'd3);
    check("prio_val", 64'(bus.cm_reg_value[63:32]), 64'hB);
    idle(); step();

    // Frozen pipeline holds a ready head.
    issue(2'd0, 1, 32'h66, 0);
    for (int i = 0; i < 3; i++) begin
      idle(); bus.rdy_in = 1'b0; step();
      check("frz_v", 64'(bus.cm_reg_valid), 64'd0);
    end
    idle(); step();
    check("frz_rel", 64'(bus.cm_reg_value[31:0]), 64'h66);

    // Asynchronous reset with five busy entries and a live commit pulse.
    for (int i = 0; i < 6; i++) issue(2'd0, 0, 32'(i), 0);
    idle(); set_wb(0, q[0].tag, 32'hAB); step();
    idle(); step();
    check("pre_rst_v", 64'(bus.cm_reg_valid[0]), 64'd1);
    do_reset();
    idle(); step();

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      int r;
      idle();
      bus.rdy_in = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 9) < 6) begin
        r = $urandom_range(0, 9);
        bus.issue_valid       = 1'b1;
        bus.issue_opcode      = (r < 6) ? 2'd0 : (r < 8) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
        bus.issue_value_ready = $urandom_range(0, 2) == 0;
        bus.issue_value       = $urandom;
        bus.issue_pc_pred     = $urandom_range(0, 1) ? 32'h200 : 32'h300;
      end
      for (int p = 0; p < WBP; p++) begin
        if ($urandom_range(0, 1) == 1) begin
          if (q.size() > 0 && $urandom_range(0, 4) != 0) begin
            int i = $urandom_range(0, q.size() - 1);
            logic [31:0] v = $urandom;
            if (q[i].op == 2'd3 && $urandom_range(0, 9) < 7) v = q[i].pred;
            if (q[i].op == 2'd2 && $urandom_range(0, 9) < 6) v[0] = q[i].val[1];
            set_wb(p, q[i].tag, v);
          end else begin
            set_wb(p, $urandom_range(0, SIZE - 1), $urandom);
          end
        end
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
